// File: rtl/updi_txn_engine.sv
// UPDI transaction sequencer: sends SYNCH, opcode and payload to the PHY, checks every echo,
// collects up to three response bytes, or runs a double break. Returns data plus an error flag.
module updi_txn_engine #(
    parameter int         RESP_TIMEOUT_CLK = 200000,
    parameter logic [7:0] SYNCH_BYTE       = 8'h55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_break,
    input  logic [7:0]  cmd_opcode,
    input  logic [1:0]  cmd_tx_len,
    input  logic [23:0] cmd_tx_data,
    input  logic [1:0]  cmd_rx_len,
    output logic        rsp_valid,
    output logic [23:0] rsp_data,
    output logic        rsp_error,
    output logic [7:0]  tx_fifo_data,
    output logic        tx_fifo_wr_en,
    input  logic        tx_fifo_full,
    input  logic [7:0]  rx_fifo_data,
    output logic        rx_fifo_rd_en,
    input  logic        rx_fifo_empty,
    input  logic        rx_error,
    output logic        db_start,
    input  logic        db_busy,
    input  logic        db_done
);

    localparam int               CNT_W        = $clog2(RESP_TIMEOUT_CLK + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RESP_TIMEOUT_CLK - 1);

    typedef enum logic [2:0] {
        IDLE,
        BRK_START,
        BRK_WAIT,
        SEND,
        ECHO,
        RECV,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [7:0]        opcode;
    logic [23:0]       tx_data;
    logic [1:0]        tx_len;
    logic [1:0]        rx_len;

    logic [2:0]        idx;
    logic              err;
    logic [CNT_W-1:0]  idle_cnt;
    logic [23:0]       rsp_buf;

    logic              accept;
    logic              pop;
    logic              in_rx;
    logic              last_push;
    logic              last_echo;
    logic              last_recv;
    logic              timeout;
    logic              echo_bad;
    logic [7:0]        cur_byte;
    logic [2:0]        send_n;
    logic [2:0]        recv_n;

    assign accept    = cmd_valid && (state == IDLE);
    assign in_rx     = (state == ECHO) || (state == RECV);
    assign send_n    = 3'd2 + {1'b0, tx_len};
    assign recv_n    = {1'b0, rx_len};

    assign cmd_ready     = (state == IDLE);
    assign tx_fifo_wr_en = (state == SEND) && !tx_fifo_full;
    assign tx_fifo_data  = (state == SEND) ? cur_byte : 8'h00;
    assign rx_fifo_rd_en = ((state == BRK_WAIT) || in_rx) && !rx_fifo_empty;
    assign db_start      = (state == BRK_START) && !db_busy;
    assign rsp_valid     = (state == DONE);
    assign rsp_error     = (state == DONE) && err;
    assign rsp_data      = rsp_buf;

    assign pop       = rx_fifo_rd_en;
    assign last_push = tx_fifo_wr_en && (idx == send_n - 3'd1);
    assign last_echo = (state == ECHO) && pop && (idx == send_n - 3'd1);
    assign last_recv = (state == RECV) && pop && (idx == recv_n - 3'd1);
    assign echo_bad  = (state == ECHO) && pop && (rx_fifo_data != cur_byte);
    // A pop in the expiring cycle keeps the transaction alive.
    assign timeout   = in_rx && !pop && (idle_cnt == TIMEOUT_LAST);

    // The same index walks the send list during SEND and the expected echoes during ECHO.
    always_comb begin
        case (idx)
            3'd0:    cur_byte = SYNCH_BYTE;
            3'd1:    cur_byte = opcode;
            3'd2:    cur_byte = tx_data[7:0];
            3'd3:    cur_byte = tx_data[15:8];
            default: cur_byte = tx_data[23:16];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = cmd_break ? BRK_START : SEND;
            end
            BRK_START: begin
                if (!db_busy) state_nxt = BRK_WAIT;
            end
            BRK_WAIT: begin
                if (db_done) state_nxt = DONE;
            end
            SEND: begin
                if (last_push) state_nxt = ECHO;
            end
            ECHO: begin
                if (timeout)        state_nxt = DONE;
                else if (last_echo) state_nxt = (rx_len == 2'd0) ? DONE : RECV;
            end
            RECV: begin
                if (timeout || last_recv) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opcode  <= cmd_opcode;
            tx_data <= cmd_tx_data;
            tx_len  <= cmd_tx_len;
            rx_len  <= cmd_rx_len;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= 3'd0;
            idle_cnt <= '0;
            err      <= 1'b0;
            rsp_buf  <= 24'h0;
        end else begin
            if (accept || last_push || last_echo)
                idx <= 3'd0;
            else if (tx_fifo_wr_en || (in_rx && pop))
                idx <= idx + 3'd1;

            if (!in_rx || pop) idle_cnt <= '0;
            else               idle_cnt <= idle_cnt + 1'b1;

            if (accept) begin
                rsp_buf <= 24'h0;
            end else if ((state == RECV) && pop) begin
                case (idx[1:0])
                    2'd0:    rsp_buf[7:0]   <= rx_fifo_data;
                    2'd1:    rsp_buf[15:8]  <= rx_fifo_data;
                    default: rsp_buf[23:16] <= rx_fifo_data;
                endcase
            end

            if (accept || (state == DONE))
                err <= 1'b0;
            else if (echo_bad || timeout || (in_rx && rx_error))
                err <= 1'b1;
        end
    end

endmodule

// File: doc/updi_txn_engine.md
# updi_txn_engine

Transaction sequencer between the UPDI command logic and the UPDI PHY. It takes one UPDI instruction per command, or one double-break request. For an instruction it pushes SYNCH (0x55), the opcode and 0-3 payload bytes into the PHY TX FIFO. It then consumes and checks the single-wire echo of every transmitted byte, collects 0-3 response bytes from the PHY RX FIFO, and returns them with an error flag (timeout, framing/parity error, or echo mismatch).

## Interface
Parameters:
- RESP_TIMEOUT_CLK, 200000: maximum idle clocks between RX bytes in ECHO/RECV; must be ≥ 1.
- SYNCH_BYTE, 8'h55: byte sent before every opcode.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle; command accepted on cmd_valid & cmd_ready
- cmd_break  in  1  1 = issue a double break; opcode, lengths and payload are ignored
- cmd_opcode  in  8  UPDI instruction byte
- cmd_tx_len  in  2  payload bytes after the opcode (0-3)
- cmd_tx_data  in  24  payload; byte i in [8i+7:8i]
- cmd_rx_len  in  2  response bytes expected after the echoes (0-3), including any ACK
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  24  response; byte i in [8i+7:8i]; unreceived bytes are 0
- rsp_error  out  1  qualified by rsp_valid
- tx_fifo_data  out  8  to PHY TX FIFO
- tx_fifo_wr_en  out  1  push strobe
- tx_fifo_full  in  1  PHY TX FIFO full
- rx_fifo_data  in  8  PHY RX FIFO head; first-word-fall-through, valid while !rx_fifo_empty
- rx_fifo_rd_en  out  1  pop strobe
- rx_fifo_empty  in  1  PHY RX FIFO empty
- rx_error  in  1  PHY UART framing/parity error
- db_start  out  1  double-break start pulse
- db_busy  in  1  double break in progress
- db_done  in  1  double break finished (one-cycle pulse)

## Operation
- States: IDLE, BRK_START, BRK_WAIT, SEND, ECHO, RECV, DONE. cmd_ready = (state == IDLE).
- On accept, latch all cmd_* fields.
  - cmd_break = 1: go to BRK_START.
  - Otherwise build the send list [SYNCH_BYTE, opcode, payload 0..tx_len-1], n = 2 + tx_len, and go to SEND.
- BRK_START: when !db_busy, assert db_start for exactly one cycle, then go to BRK_WAIT.
- BRK_WAIT: pop the RX FIFO whenever it is non-empty; these bytes are break garbage and are discarded. On db_done go to DONE with rsp_error = 0 and rsp_data = 0.
- SEND: each cycle with !tx_fifo_full, push the next list byte. After byte n-1 is pushed, go to ECHO.
- ECHO: pop one byte per cycle while !rx_fifo_empty. Compare popped byte k with send-list byte k; any mismatch sets a sticky error. All n echoes are always consumed so the stream stays aligned. After n pops, go to RECV, or go directly to DONE if rx_len = 0.
- RECV: pop bytes into rsp_data slots 0..rx_len-1. After rx_len pops, go to DONE.
- Sticky error: rx_error high in any cycle of ECHO or RECV sets it.
- Timeout in ECHO/RECV:
  - The counter clears on entry and on every pop, and increments otherwise.
  - When it reaches RESP_TIMEOUT_CLK, set the error and go to DONE. Slots not yet filled stay 0.
- DONE: rsp_valid = 1 for one cycle, rsp_error = sticky error. The sticky error then clears and the state returns to IDLE.
- rsp_data holds its value until the next accepted command, which clears it to 0.

## Timing
- Reset values: cmd_ready 1; rsp_valid 0; rsp_data 0; rsp_error 0; tx_fifo_wr_en 0; tx_fifo_data 0; rx_fifo_rd_en 0; db_start 0. State resets to IDLE and the counter to 0.
- Accept in cycle t puts the first push (SYNCH) in cycle t+1 when the TX FIFO is not full. There is one push per non-full cycle, so n pushes take ≥ n cycles.
- Full stall: a byte is not advanced while tx_fifo_full = 1; tx_fifo_wr_en = 0 in those cycles.
- Pop rule: rx_fifo_rd_en = state ∈ {BRK_WAIT, ECHO, RECV} & !rx_fifo_empty. Data is sampled in the same cycle. There are never more pops than required in ECHO/RECV.
- Completion: rsp_valid fires one cycle after the last pop, timeout or db_done. cmd_ready returns to 1 in the cycle after rsp_valid.
- Timeout and last pop in the same cycle: the pop wins and no timeout error is raised.
- Reset asserted mid-transaction: abort immediately to reset values, with no rsp_valid. Bytes already pushed to the PHY are not recalled.

## Test plan
- Break: cmd_break=1 with the PHY driving db_busy for 50 cycles, then db_done, and 2 junk RX bytes -> one db_start pulse, both junk bytes popped, rsp_valid with rsp_error=0 and rsp_data=0.
- LDCS: opcode 0x80, tx_len 0, rx_len 1; loopback echoes 0x55, 0x80, then device returns 0x30 -> pushes 0x55, 0x80; rsp_data=24'h000030; rsp_error=0.
- STS with ACK: opcode 0x44, tx_len 3, payload 24'h12_34_56, rx_len 1, ACK 0x40 -> pushes 55 44 56 34 12; rsp_data=24'h000040; rsp_error=0.
- Echo mismatch: second echo returned as 0x81 instead of 0x80, rx_len 1 with response 0x30 -> all echoes still consumed, rsp_data=24'h000030, rsp_error=1.
- Timeout: RESP_TIMEOUT_CLK=100, rx_len 2, only 1 response byte 0xAA arrives -> rsp_valid exactly 100 idle cycles after the last pop, rsp_data=24'h0000AA, rsp_error=1.
- Backpressure and reset: hold tx_fifo_full for 20 cycles mid-SEND -> no pushes while full, and byte order is preserved; assert rst during RECV -> all outputs return to reset values, with no rsp_valid.
